// File: rtl/alu_op_driver.sv
// alu_op_driver: initiator side of the core's ALU port group.
//
// Requests (operands, control code, tag) are accepted over a valid/ready handshake and
// loaded into registers that drive the ALU inputs directly. One cycle later the ALU's
// combinational result and zero flag are captured, together with the request tag, into
// a response FIFO. The FIFO head is returned over a second valid/ready handshake.
//
// Ports
//   CLK, RESET_N                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_a, req_b, req_op, req_tag  request payload
//   A_alu, B_alu, control_alu      registered ALU inputs, changed only on an accepted request
//   result_alu, zero_alu           ALU outputs, sampled one cycle after issue
//   rsp_valid/rsp_ready            response handshake (FIFO head)
//   rsp_result, rsp_zero, rsp_tag  response payload, shown combinationally from the FIFO head
//   op_count                       count of captured operations, wraps modulo 2^16
module alu_op_driver #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [4:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,

  output logic [31:0]      A_alu,
  output logic [31:0]      B_alu,
  output logic [4:0]       control_alu,
  input  logic [31:0]      result_alu,
  input  logic             zero_alu,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,

  output logic [15:0]      op_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = 32 + 1 + TAG_W;

  // Issue stage
  logic             s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0] s1_tag_q;
  logic [31:0]      a_q, b_q;
  logic [4:0]       ctl_q;

  // Response FIFO; the extra pointer bit distinguishes full from empty
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic [EntW-1:0]  mem_q [DEPTH];
  logic [EntW-1:0]  head;
  logic [EntW-1:0]  push_entry;

  logic [15:0]      op_count_q, op_count_d;

  logic full, empty;
  logic req_fire, rsp_fire, cap_fire;

  // Handshake and FIFO status
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
               (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    rsp_fire = !empty && rsp_ready;
    // A pop in the same cycle frees the slot, so capture is allowed even when full.
    cap_fire = s1_valid_q && (!full || rsp_fire);
    req_fire = req_valid && (!s1_valid_q || cap_fire);
  end

  assign req_ready = !s1_valid_q || cap_fire;

  // Next-state for issue flag, pointers and counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    op_count_d = op_count_q;

    if (req_fire) begin
      s1_valid_d = 1'b1;
    end else if (cap_fire) begin
      s1_valid_d = 1'b0;
    end

    if (cap_fire) begin
      wr_ptr_d   = wr_ptr_q + (PtrW + 1)'(1);
      op_count_d = op_count_q + 16'd1;
    end

    if (rsp_fire) begin
      rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  // ALU input registers only move on an accepted request, keeping the ALU quiet otherwise.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      s1_tag_q <= '0;
    end else if (req_fire) begin
      a_q      <= req_a;
      b_q      <= req_b;
      ctl_q    <= req_op;
      s1_tag_q <= req_tag;
    end
  end

  assign push_entry = {result_alu, zero_alu, s1_tag_q};

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge CLK) begin
    if (cap_fire) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= push_entry;
    end
  end

  assign head = mem_q[rd_ptr_q[PtrW-1:0]];

  assign A_alu       = a_q;
  assign B_alu       = b_q;
  assign control_alu = ctl_q;

  assign rsp_valid  = !empty;
  assign rsp_result = head[EntW-1 -: 32];
  assign rsp_zero   = head[TAG_W];
  assign rsp_tag    = head[TAG_W-1:0];

  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver with a stub adder ALU. A queue-based model tracks the pending
// issue and the ordered responses; a compare process checks every cycle, and directed
// scenarios add hand-computed literal checks.
module tb_alu_op_driver;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [4:0]       req_op = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      A_alu, B_alu;
  logic [4:0]       control_alu;
  logic [31:0]      result_alu;
  logic             zero_alu;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      op_count;

  alu_op_driver #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .A_alu(A_alu), .B_alu(B_alu), .control_alu(control_alu),
    .result_alu(result_alu), .zero_alu(zero_alu),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .op_count(op_count)
  );

  always #5 CLK = ~CLK;

  // Stub ALU
  assign result_alu = A_alu + B_alu;
  assign zero_alu   = (result_alu == 32'd0);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: last accepted request (also what the ALU inputs must show),
  // whether it still awaits capture, and the ordered list of captured responses.
  bit                        m_s1v;
  logic [31:0]               m_a, m_b;
  logic [4:0]                m_op;
  logic [TAG_W-1:0]          m_tag;
  logic [32+1+TAG_W-1:0]     m_q[$];
  logic [15:0]               m_cnt;
  bit                        m_rf, m_pf, m_cf;
  logic [31:0]               m_sum;

  function automatic bit m_ready();
    return !m_s1v || (m_q.size() < DEPTH) || (rsp_ready && m_q.size() > 0);
  endfunction

  initial begin
    m_s1v = 0; m_a = 0; m_b = 0; m_op = 0; m_tag = 0; m_cnt = 0;
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) begin
        m_s1v = 0; m_a = 0; m_b = 0; m_op = 0; m_tag = 0; m_cnt = 0;
        m_q.delete();
      end else begin
        m_rf  = req_valid && m_ready();
        m_pf  = rsp_ready && (m_q.size() > 0);
        m_cf  = m_s1v && ((m_q.size() < DEPTH) || m_pf);
        m_sum = m_a + m_b;
        if (m_pf) void'(m_q.pop_front());
        if (m_cf) begin
          m_q.push_back({m_sum, m_sum == 32'd0, m_tag});
          m_cnt = m_cnt + 16'd1;
        end
        if (m_rf) begin
          m_s1v = 1; m_a = req_a; m_b = req_b; m_op = req_op; m_tag = req_tag;
        end else if (m_cf) begin
          m_s1v = 0;
        end
      end
    end
  end

  // Per-cycle comparison and log of delivered tags
  logic [TAG_W-1:0] got[$];

  initial begin
    forever begin
      @(negedge CLK);
      chk("req_ready", 64'(req_ready), 64'(m_ready()));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) chk("rsp_head", 64'({rsp_result, rsp_zero, rsp_tag}), 64'(m_q[0]));
      chk("A_alu", 64'(A_alu), 64'(m_a));
      chk("B_alu", 64'(B_alu), 64'(m_b));
      chk("control_alu", 64'(control_alu), 64'(m_op));
      chk("op_count", 64'(op_count), 64'(m_cnt));
      if (rsp_valid && rsp_ready) got.push_back(rsp_tag);
    end
  end

  // Presents one request and returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                      input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 0;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge CLK);
      if (req_ready) begin
        @(posedge CLK);
        ok = 1;
      end
    end
    #1;
    req_valid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random requests present
    RESET_N = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      req_a = $urandom; req_b = $urandom; req_op = 5'($urandom); req_tag = TAG_W'($urandom);
    end
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_A", 64'(A_alu), 64'd0);
    chk("rst_ctl", 64'(control_alu), 64'd0);
    chk("rst_cnt", 64'(op_count), 64'd0);
    req_valid = 1'b0;
    step(1);
    RESET_N = 1'b1;
    step(3);
    chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);

    // Single op
    send(32'd5, 32'd7, 5'd3, 4'd2);
    chk("single_ctl", 64'(control_alu), 64'd3);
    chk("single_A", 64'(A_alu), 64'd5);
    step(1);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_result", 64'(rsp_result), 64'd12);
    chk("single_zero", 64'(rsp_zero), 64'd0);
    chk("single_tag", 64'(rsp_tag), 64'd2);
    chk("single_cnt", 64'(op_count), 64'd1);

    // Zero flag and sign-boundary sum
    send(32'hFFFF_FFFF, 32'd1, 5'd0, 4'd3);
    step(1);
    chk("zero_result", 64'(rsp_result), 64'd0);
    chk("zero_flag", 64'(rsp_zero), 64'd1);
    chk("zero_tag", 64'(rsp_tag), 64'd3);
    send(32'h7FFF_FFFF, 32'd1, 5'd0, 4'd4);
    step(1);
    chk("ovf_result", 64'(rsp_result), 64'h8000_0000);
    chk("ovf_zero", 64'(rsp_zero), 64'd0);
    step(2);

    // Back-pressure: DEPTH in FIFO plus one in issue
    got.delete();
    rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) send(32'd100 + 32'(t), 32'(t), 5'd1, TAG_W'(t));
    req_a = 32'd105; req_b = 32'd5; req_op = 5'd1; req_tag = 4'd5; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_A_stable", 64'(A_alu), 64'd104);
    end
    step(1);
    rsp_ready = 1'b1;
    for (int t = 5; t < 8; t++) send(32'd100 + 32'(t), 32'(t), 5'd1, TAG_W'(t));
    step(8);
    chk("bp_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_order", 64'(got[i]), 64'(i));

    // Push and pop in one cycle while full
    got.delete();
    rsp_ready = 1'b0;
    for (int t = 8; t < 13; t++) send(32'(t), 32'd1, 5'd2, TAG_W'(t));
    step(1);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    chk("pp_one_pop", 64'(got.size()), 64'd1);
    chk("pp_head", 64'(rsp_tag), 64'd9);
    chk("pp_s1_cleared", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    step(6);
    chk("pp_total", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("pp_order", 64'(got[i]), 64'(8 + i));

    // Reset mid-stream: 3 queued plus one in issue
    got.delete();
    rsp_ready = 1'b0;
    for (int t = 1; t < 5; t++) send(32'(t), 32'd2, 5'd4, TAG_W'(t));
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_cnt", 64'(op_count), 64'd0);
    step(1);
    RESET_N = 1'b1;
    rsp_ready = 1'b1;
    send(32'd9, 32'd9, 5'd2, 4'd9);
    step(3);
    chk("mid_rst_first_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("mid_rst_first_tag", 64'(got[0]), 64'd9);

    // op_count wrap
    RESET_N = 1'b0;
    step(1);
    RESET_N = 1'b1;
    for (int i = 0; i < 65537; i++) send(32'(i), 32'(i), 5'(i), TAG_W'(i));
    step(2);
    chk("wrap_cnt", 64'(op_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Initiator side of the core's ALU interface. It accepts operation requests over a valid/ready handshake and drives registered, stable operands and control onto the ALU inputs. It samples the ALU's combinational result and zero flag one cycle later and returns them, tagged, through a response FIFO with its own valid/ready handshake. It sits between the core and test sequencers upstream and the ALU's A/B/control/result/zero port group downstream.

## Interface
- TAG_W, 4, width of the request/response tag
- DEPTH, 4, response FIFO depth; power of two, at least 2
- CLK  in  1  clock; all state updates on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_op  in  5  ALU control code, passed through unmodified
- req_tag  in  TAG_W  request tag
- A_alu  out  32  ALU operand A (registered)
- B_alu  out  32  ALU operand B (registered)
- control_alu  out  5  ALU control (registered)
- result_alu  in  32  ALU result (combinational from A/B/control)
- zero_alu  in  1  ALU zero flag
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer takes the head
- rsp_result  out  32  head result
- rsp_zero  out  1  head zero flag
- rsp_tag  out  TAG_W  head tag
- op_count  out  16  number of captured operations; wraps modulo 2^16

## Operation
- req_fire = req_valid && req_ready. rsp_fire = rsp_valid && rsp_ready.
- Issue stage: the s1_valid flag and the s1_tag register, plus the A_alu/B_alu/control_alu registers.
  - On req_fire, load req_a, req_b, req_op and req_tag, and set s1_valid.
- Capture:
  - cap_fire = s1_valid && (!full || rsp_fire).
  - On cap_fire, push {result_alu, zero_alu, s1_tag} into the FIFO and increment op_count.
  - Clear s1_valid unless req_fire occurs in the same cycle.
- req_ready = !s1_valid || cap_fire. This gives back-to-back acceptance of one request per cycle while the FIFO drains.
- ALU input registers change only on req_fire. Between requests they hold their last values, so no spurious ALU toggling.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH)+1 bits, wrapping naturally.
  - full when the pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - Push and pop in the same cycle are allowed at any occupancy, including full (cap_fire is then permitted by rsp_fire). Occupancy is unchanged.
  - Pop on empty is impossible because rsp_valid = !empty.
  - rsp_* outputs show the head entry combinationally from storage.
- Responses leave in request order; tags are never reordered or altered.
- Reset:
  - Outputs: A_alu = 0, B_alu = 0, control_alu = 0, s1_valid = 0, FIFO empty, rsp_valid = 0, op_count = 0, req_ready = 1.
  - Internal: read and write pointers = 0.
  - Reset asserted mid-operation discards the in-flight issue and all FIFO contents. No response for them is ever produced.

## Timing
- Request accepted at edge N. The ALU inputs are valid from N until the next req_fire.
- The result is captured at edge N+1 if the FIFO is not full. rsp_valid rises after edge N+1 when the FIFO was empty.
- Minimum latency from request acceptance to response availability: 1 cycle after the accepting edge, i.e. visible in the cycle following the capture edge.
- Throughput: 1 operation per cycle while rsp_ready stays high.
- With the FIFO full and rsp_ready low:
  - s1 holds, req_ready = 0, and the ALU inputs stay stable.
  - The capture re-samples result_alu on the cycle the stall releases. The ALU is combinational and its inputs are unchanged, so the sampled value is identical.
- Capacity: DEPTH responses in the FIFO plus 1 in s1. req_ready deasserts after DEPTH+1 unacknowledged requests.

## Test plan
All scenarios use a stub ALU: result_alu = A_alu + B_alu, zero_alu = (result_alu == 0).
- Reset: hold RESET_N low, drive random requests -> req_ready = 1, rsp_valid = 0, A_alu/B_alu/control_alu = 0, op_count = 0. After release, no response appears.
- Single op: A = 5, B = 7, op = 5'd3, tag = 2, rsp_ready = 1 -> control_alu = 3 one edge after acceptance, then rsp_result = 12, rsp_zero = 0, rsp_tag = 2, op_count = 1.
- Zero flag: A = 32'hFFFF_FFFF, B = 1 -> rsp_result = 0, rsp_zero = 1. Also 32'h7FFF_FFFF + 1 -> 32'h8000_0000, rsp_zero = 0.
- Back-pressure/full (DEPTH = 4): rsp_ready = 0, stream tags 0..7 -> exactly 5 requests accepted (tags 0-4), then req_ready = 0 and A_alu stable. Raising rsp_ready returns tags 0..7 in order with no loss or duplication.
- Simultaneous push/pop at full: keep the FIFO full, assert rsp_ready for 1 cycle with s1 valid -> one pop and one push in the same cycle, occupancy stays 4, order is preserved.
- Reset mid-stream: assert RESET_N low with 3 entries queued and s1 valid -> rsp_valid = 0 immediately (asynchronous). After release, new tag 9 returns as the first response. Check op_count wrap separately by issuing 65537 ops -> op_count = 1.
